uart_rx_word: RTL and testbench

UART_RX_WORD -- requirements
Module: uart_rx_word

---
 rtl/uart_rx_word.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_word.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// uart_rx_word
//   Oversampling UART receiver that collects four bytes (LSB byte first)
//   into a 32-bit word and presents the word only after all four bytes are received.
//   Each byte arrives as 8N1. When UART_RX_PARITY_EN is defined, each byte
//   arrives as 8E1 instead.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (even, 4..65535)
//   TIMEOUT_BITS  idle bit-times tolerated between bytes of one word
//
// Optional feature macro
//   UART_RX_PARITY_EN  adds an even-parity bit after the data bits
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   Rx           asynchronous serial input, idle high
//   RxData       last complete word (bytes 0..3 -> [7:0]..[31:24])
//   RxValid      1-cycle pulse, RxData updated
//   RxFrameErr   1-cycle pulse, stop bit sampled low
//   RxParityErr  1-cycle pulse, parity mismatch (0 without parity)
//   RxBusy       high while the receiver is not idle
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Rx,
  output logic [31:0] RxData,
  output logic        RxValid,
  output logic        RxFrameErr,
  output logic        RxParityErr,
  output logic        RxBusy
);

  localparam int HALF_BIT       = CLKS_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CLKS_PER_BIT);
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_t;
`endif

  state_t            state_reg;
  logic              rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [CNT_W-1:0]  clk_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic [1:0]        byte_idx_reg;
  logic [23:0]       word_buf_reg;
  logic [TO_W-1:0]   idle_cnt_reg;
  logic [31:0]       data_reg;
  logic              valid_reg, frame_err_reg, parity_err_reg, busy_reg;

  wire sample_mid  = (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  wire start_edge  = rx_prev_reg & ~rx_sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizer resets to the idle level so a high line after reset
      // cannot look like a start edge.
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_prev_reg    <= 1'b1;
      state_reg      <= IDLE;
      clk_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      byte_idx_reg   <= '0;
      word_buf_reg   <= '0;
      idle_cnt_reg   <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      rx_meta_reg    <= Rx;
      rx_sync_reg    <= rx_meta_reg;
      rx_prev_reg    <= rx_sync_reg;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // Inter-byte timeout only runs while a partial word is pending.
          if (byte_idx_reg != 2'd0) begin
            if (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
              byte_idx_reg <= 2'd0;
              idle_cnt_reg <= '0;
            end else begin
              idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
          end else begin
            idle_cnt_reg <= '0;
          end
          // A start edge coinciding with timeout expiry still starts a
          // byte; it lands at index 0 because of the clear above.
          if (start_edge) begin
            state_reg    <= START;
            busy_reg     <= 1'b1;
            clk_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            idle_cnt_reg <= '0;
          end
        end

        START: begin
          if (clk_cnt_reg == CNT_W'(HALF_BIT - 1)) begin
            clk_cnt_reg <= '0;
            if (rx_sync_reg) begin
              state_reg <= IDLE;   // glitch, silently ignored
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= DATA;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        DATA: begin
          if (sample_mid) begin
            clk_cnt_reg <= '0;
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_mid) begin
            clk_cnt_reg <= '0;
            if (rx_sync_reg != ^shift_reg) begin
              parity_err_reg <= 1'b1;
              byte_idx_reg   <= 2'd0;
              state_reg      <= WAIT_HIGH;
            end else begin
              state_reg <= STOP;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (sample_mid) begin
            clk_cnt_reg <= '0;
            if (rx_sync_reg) begin
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              idle_cnt_reg <= '0;
              case (byte_idx_reg)
                2'd0: word_buf_reg[7:0]   <= shift_reg;
                2'd1: word_buf_reg[15:8]  <= shift_reg;
                2'd2: word_buf_reg[23:16] <= shift_reg;
                default: begin
                  data_reg  <= {shift_reg, word_buf_reg};
                  valid_reg <= 1'b1;
                end
              endcase
              byte_idx_reg <= byte_idx_reg + 1'b1;  // 3 wraps to 0
            end else begin
              frame_err_reg <= 1'b1;
              byte_idx_reg  <= 2'd0;
              state_reg     <= WAIT_HIGH;
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end

        WAIT_HIGH: begin
          // Holding here during a break keeps it to a single error pulse.
          if (rx_sync_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign RxData      = data_reg;
  assign RxValid     = valid_reg;
  assign RxFrameErr  = frame_err_reg;
  assign RxParityErr = parity_err_reg;
  assign RxBusy      = busy_reg;

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word.
// Bytes are driven onto Rx at the bit level. A transaction-level model tracks
// which bytes are received and which bytes are discarded. The model then
// predicts the word stream and the error-pulse counts.
module tb_uart_rx_word;
  localparam int CPB  = 16;
  localparam int TOUT = 32;

  logic        clk;
  logic        reset;
  logic        Rx;
  logic [31:0] RxData;
  logic        RxValid, RxFrameErr, RxParityErr, RxBusy;

  uart_rx_word #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOUT)) dut (
    .clk(clk), .reset(reset), .Rx(Rx), .RxData(RxData), .RxValid(RxValid),
    .RxFrameErr(RxFrameErr), .RxParityErr(RxParityErr), .RxBusy(RxBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: the transaction-level view of the word assembler.
  logic [7:0]  mbytes[$];
  logic [31:0] exp_q[$];
  int exp_ferr = 0;
  int exp_perr = 0;

  task automatic model_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    if (bad_par) begin
      exp_perr++;
      mbytes.delete();
    end else if (bad_stop) begin
      exp_ferr++;
      mbytes.delete();
    end else begin
      mbytes.push_back(b);
      if (mbytes.size() == 4) begin
        exp_q.push_back({mbytes[3], mbytes[2], mbytes[1], mbytes[0]});
        mbytes.delete();
      end
    end
  endtask

  task automatic model_gap(input int bits);
    if (bits > TOUT) mbytes.delete();
  endtask

  // Monitor: records output pulses and tracks invariants on the opposite edge.
  logic [31:0] got_q[$];
  int got_ferr = 0;
  int got_perr = 0;
  int excl_viol = 0;
  int hold_viol = 0;
  logic [31:0] last_data;

  always @(negedge clk) begin
    if (reset) begin
      last_data = RxData;
    end else begin
      if (RxValid) got_q.push_back(RxData);
      if (RxFrameErr) got_ferr++;
      if (RxParityErr) got_perr++;
      if (int'(RxValid) + int'(RxFrameErr) + int'(RxParityErr) > 1) excl_viol++;
      if (!RxValid && RxData !== last_data) hold_viol++;
      last_data = RxData;
    end
  end

  task automatic bit_time(input logic v);
    Rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                            input int gap_bits);
    logic [7:0] d;
    d = b;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^d) ^ bad_par);
`endif
    bit_time(~bad_stop);
    Rx = 1'b1;
    repeat (gap_bits * CPB) @(negedge clk);
    model_frame(b, bad_stop, bad_par);
    model_gap(gap_bits);
    $display("tx byte 0x%02h bad_stop=%0d bad_par=%0d gap=%0d", b, bad_stop, bad_par, gap_bits);
  endtask

  task automatic verify(input string tag);
    int n;
    repeat (2 * CPB) @(negedge clk);
    n = (exp_q.size() < got_q.size()) ? exp_q.size() : got_q.size();
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      check({tag, "_word"}, got_q[i], exp_q[i]);
      $display("%s word %0d got 0x%08h exp 0x%08h", tag, i, got_q[i], exp_q[i]);
    end
    check({tag, "_ferr"}, got_ferr, exp_ferr);
    check({tag, "_perr"}, got_perr, exp_perr);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         gap, n;
    bit         bs, bp;

    reset = 1'b1;
    Rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data", RxData, 32'h0);
    check("rst_valid", RxValid, 1'b0);
    check("rst_ferr", RxFrameErr, 1'b0);
    check("rst_perr", RxParityErr, 1'b0);
    check("rst_busy", RxBusy, 1'b0);
    reset = 1'b0;
    repeat (CPB) @(negedge clk);

    // Back-to-back word.
    send_frame(8'hEF, 0, 0, 0);
    send_frame(8'hBE, 0, 0, 0);
    send_frame(8'hAD, 0, 0, 0);
    send_frame(8'hDE, 0, 0, 2);
    verify("deadbeef");

    // Short low glitch while idle.
    Rx = 1'b0;
    repeat (4) @(negedge clk);
    Rx = 1'b1;
    n = 0;
    while (RxBusy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy", RxBusy, 1'b0);
    verify("glitch");

    // Framing error on byte 2, then a clean word.
    send_frame(8'hA0, 0, 0, 0);
    send_frame(8'hA1, 0, 0, 0);
    send_frame(8'hA2, 1, 0, 1);
    send_frame(8'h78, 0, 0, 0);
    send_frame(8'h56, 0, 0, 0);
    send_frame(8'h34, 0, 0, 0);
    send_frame(8'h12, 0, 0, 2);
    verify("frame_err");

    // Inter-byte timeout drops a partial word.
    send_frame(8'h11, 0, 0, 0);
    send_frame(8'h22, 0, 0, 40);
    send_frame(8'h01, 0, 0, 0);
    send_frame(8'h02, 0, 0, 0);
    send_frame(8'h03, 0, 0, 0);
    send_frame(8'h04, 0, 0, 2);
    verify("timeout");

    // Reset in the middle of byte 1. The remainder of that frame on the line
    // is high, so no spurious frame should follow.
    send_frame(8'h55, 0, 0, 1);
    rb = 8'hF8;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) reset = 1'b1;
      if (i == 5) reset = 1'b0;
      if (i == 3) begin
        check("midrst_data", RxData, 32'h0);
        check("midrst_busy", RxBusy, 1'b0);
      end
      bit_time(rb[i]);
    end
`ifdef UART_RX_PARITY_EN
    bit_time(^rb);
`endif
    bit_time(1'b1);
    mbytes.delete();
    Rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("postrst_data", RxData, 32'h0);
    send_frame(8'hAA, 0, 0, 0);
    send_frame(8'hBB, 0, 0, 0);
    send_frame(8'hCC, 0, 0, 0);
    send_frame(8'hDD, 0, 0, 2);
    verify("reset");

`ifdef UART_RX_PARITY_EN
    // Parity error discards the byte; the next four bytes form a word.
    send_frame(8'h5A, 0, 1, 0);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 0, 0, 0);
    verify("parity");
`endif

    // Randomized traffic: short gaps, occasional timeouts, and injected errors.
    for (int k = 0; k < 40; k++) begin
      rb  = 8'($urandom);
      bs  = ($urandom_range(0, 9) == 0);
      bp  = 1'b0;
`ifdef UART_RX_PARITY_EN
      if (!bs) bp = ($urandom_range(0, 9) == 0);
`endif
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(40, 50)) : int'($urandom_range(0, 3));
      if (bs && gap == 0) gap = 1;
      send_frame(rb, bs, bp, gap);
    end
    verify("random");

    check("onehot_pulses", excl_viol, 0);
    check("data_hold", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
